router_pkt_tx: RTL and testbench
================================

Name: router_pkt_tx

Overview:
- Packet transmitter that drives the router input interface (pkt_valid, 8-bit data, busy, err) from a host-side command/payload handshake.
- Buffers a complete payload first, then sends header, payload and parity without gaps in pkt_valid. Stalls on busy.
- Watches err after parity and reports per-packet status.
- Sits in front of the router as the traffic source for the system and the bench.

Parameters:
- CHK_CYCLES, 3, cycles after the parity byte is accepted during which err is sampled (range 1..15).
- MAX_RETRY, 2, resend attempts after err; used only with ROUTER_PKT_TX_RETRY_EN (range 0..3).

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- cmd_valid  in  1  host command valid.
- cmd_ready  out  1  command accepted on the edge where cmd_valid and cmd_ready are both 1.
- cmd_addr  in  2  destination port; 0..2 legal.
- cmd_len  in  6  payload length in bytes; 1..63 legal.
- pld_valid  in  1  payload byte valid.
- pld_ready  out  1  payload byte accepted on the edge where pld_valid and pld_ready are both 1.
- pld_data  in  8  payload byte.
- pkt_valid  out  1  to router pkt_valid.
- data_out  out  8  to router data_in.
- busy  in  1  router busy; while 1, the current byte is not consumed.
- err  in  1  router parity error flag.
- tx_done  out  1  one-cycle pulse at the end of each command (sent or rejected).
- tx_err  out  1  status, valid with tx_done: 1 means err was seen, or the command was rejected.
- tx_rej  out  1  status, valid with tx_done: 1 means illegal command, nothing transmitted.

Behaviour:
- Reset values (next edge with reset=1, in any state): state IDLE; cmd_ready, pld_ready, pkt_valid, tx_done, tx_err, tx_rej = 0; data_out = 8'h00; all counters and parity cleared.
- A packet abandoned mid-flight by reset is not completed; the router is reset with the system.
- All outputs are registered.
- A byte is consumed at a rising edge where the state is HDR, PLD or PAR and busy=0. The next byte is on data_out immediately after that edge. With busy=1, data_out and pkt_valid hold.
- IDLE: cmd_ready=1.
  - On accept with cmd_addr=3 or cmd_len=0: tx_done=1, tx_rej=1, tx_err=1 for one cycle; stay in IDLE.
  - On a legal accept: latch addr and len; cmd_ready=0, pld_ready=1; go to FILL.
- FILL: each accepted byte is written to buf[wr_cnt] and wr_cnt increments.
  - The edge accepting byte len-1 sets pld_ready=0, presents header {len, addr} with pkt_valid=1, loads parity=header, and goes to HDR.
  - pld_valid gaps simply wait.
- HDR: on consume, present buf[0] and go to PLD with rd_cnt=0.
- PLD: pkt_valid=1, data_out=buf[rd_cnt].
  - On consume: parity ^= byte; rd_cnt increments.
  - On the consume of byte len-1: present pkt_valid=0, data_out=parity; go to PAR.
- PAR: on consume, data_out=8'h00, clear the sticky error flag, load the check counter with CHK_CYCLES; go to CHK.
- CHK: sticky error flag |= err each cycle. When the counter expires: tx_done=1 and tx_err=sticky for one cycle, tx_rej=0; go to IDLE.
  - cmd_ready returns the cycle after tx_done, so there are at least CHK_CYCLES+1 idle cycles between packets.
- Buffer: 64x8. Read latency is hidden, so no bubble between bytes when busy=0.
- Minimum packet time with no stalls: len fill cycles + 1 header + len payload + 1 parity + CHK_CYCLES.
- Parity: XOR of the header and all payload bytes, 8 bits, no carry.
- cmd_valid during a non-IDLE state is ignored (not accepted). pld_valid outside FILL is ignored.

Optional Feature:
- ROUTER_PKT_TX_RETRY_EN defined: if the sticky error flag is set at the end of CHK and retries < MAX_RETRY, increment retries and go to HDR to resend the same packet from buf, with parity recomputed. No tx_done is issued for the failed attempt.
  - tx_done/tx_err are issued only on a clean pass, or with tx_err=1 after MAX_RETRY failed resends.
  - The retry count clears on each new command.
- Not defined: no resend; every packet ends with tx_done, tx_err as sampled.

Test Plan:
- Basic send:
  - Stimulus: addr=1, len=3, payload A5,3C,0F, busy=0, err=0.
  - Required: data_out sequence 0D(pv=1), A5, 3C, 0F, 9B(pv=0); tx_done with tx_err=0 CHK_CYCLES=3 cycles after the parity consume.
- Busy stall:
  - Stimulus: same packet, busy=1 for 2 cycles while 3C is presented.
  - Required: data_out stays 3C and pkt_valid stays 1 for 3 cycles; parity is still 9B.
- Reject:
  - Stimulus: cmd addr=3, len=4; then a separate cmd addr=0, len=0.
  - Required: each gives a one-cycle tx_done, tx_rej=1, tx_err=1; pkt_valid never rises; pld_ready stays 0.
- Error report:
  - Stimulus: addr=2, len=1, payload 00; err pulsed for 1 cycle, 2 cycles into CHK.
  - Required (macro off): tx_err=1.
  - Required (macro on, MAX_RETRY=2): packet resent, header 06; err held high on every attempt gives 3 transmissions then tx_err=1.
- Max length and reset:
  - Stimulus: len=63, payload 00..3E. Then repeat, asserting reset at payload byte 20.
  - Required: first run gives header FC, 63 payload bytes, parity = XOR of all; second run gives pkt_valid=0, data_out=00, cmd_ready=0 at the next edge, and IDLE with cmd_ready=1 one cycle after reset drops.

Source files
------------

// File: rtl/router_pkt_tx.sv
// Router packet transmitter: buffers a host payload, then sends header, payload and parity to the router.
// Optional resend-on-error behaviour is enabled by defining ROUTER_PKT_TX_RETRY_EN.
module router_pkt_tx #(
    parameter int CHK_CYCLES = 3,
    parameter int MAX_RETRY  = 2
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [1:0] cmd_addr,
    input  logic [5:0] cmd_len,
    input  logic       pld_valid,
    output logic       pld_ready,
    input  logic [7:0] pld_data,
    output logic       pkt_valid,
    output logic [7:0] data_out,
    input  logic       busy,
    input  logic       err,
    output logic       tx_done,
    output logic       tx_err,
    output logic       tx_rej
);

`ifdef ROUTER_PKT_TX_RETRY_EN
    localparam bit RETRY_EN = 1'b1;
`else
    localparam bit RETRY_EN = 1'b0;
`endif

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        FILL = 3'd1,
        HDR  = 3'd2,
        PLD  = 3'd3,
        PAR  = 3'd4,
        CHK  = 3'd5
    } state_t;

    function automatic logic [7:0] par_acc(input logic [7:0] acc, input logic [7:0] b);
        return acc ^ b;
    endfunction

    state_t     state_r, state_s;
    logic [1:0] addr_r, addr_s;
    logic [5:0] len_r, len_s;
    logic [5:0] wr_cnt_r, wr_cnt_s;
    logic [5:0] rd_cnt_r, rd_cnt_s;
    logic [7:0] parity_r, parity_s;
    logic       sticky_r, sticky_s;
    logic [3:0] chk_cnt_r, chk_cnt_s;
    logic [1:0] retry_r, retry_s;
    logic       cmd_ready_s, pld_ready_s, pkt_valid_s;
    logic [7:0] data_out_s;
    logic       tx_done_s, tx_err_s, tx_rej_s;
    logic       err_seen_s;
    logic       wr_en_s;
    logic [7:0] hdr_s;
    logic [7:0] pld_mem [0:63];

    assign hdr_s   = {len_r, addr_r};
    assign wr_en_s = (state_r == FILL) && pld_valid && pld_ready;

    // Payload buffer write port; contents need no reset.
    always_ff @(posedge clock) begin
        if (wr_en_s) begin
            pld_mem[wr_cnt_r] <= pld_data;
        end
    end

    // Next-state and next-output logic; the following byte is read from the buffer
    // combinationally so it is already registered on data_out when a byte is consumed.
    always_comb begin
        state_s     = state_r;
        addr_s      = addr_r;
        len_s       = len_r;
        wr_cnt_s    = wr_cnt_r;
        rd_cnt_s    = rd_cnt_r;
        parity_s    = parity_r;
        sticky_s    = sticky_r;
        chk_cnt_s   = chk_cnt_r;
        retry_s     = retry_r;
        cmd_ready_s = 1'b0;
        pld_ready_s = 1'b0;
        pkt_valid_s = pkt_valid;
        data_out_s  = data_out;
        tx_done_s   = 1'b0;
        tx_err_s    = 1'b0;
        tx_rej_s    = 1'b0;
        err_seen_s  = 1'b0;
        case (state_r)
            IDLE: begin
                if (cmd_valid && cmd_ready) begin
                    if ((cmd_addr == 2'd3) || (cmd_len == 6'd0)) begin
                        tx_done_s   = 1'b1;
                        tx_err_s    = 1'b1;
                        tx_rej_s    = 1'b1;
                        cmd_ready_s = 1'b1;
                    end else begin
                        addr_s      = cmd_addr;
                        len_s       = cmd_len;
                        wr_cnt_s    = 6'd0;
                        retry_s     = 2'd0;
                        pld_ready_s = 1'b1;
                        state_s     = FILL;
                    end
                end else begin
                    cmd_ready_s = 1'b1;
                end
            end
            FILL: begin
                if (pld_valid && pld_ready) begin
                    wr_cnt_s = wr_cnt_r + 6'd1;
                    if (wr_cnt_r == (len_r - 6'd1)) begin
                        pkt_valid_s = 1'b1;
                        data_out_s  = hdr_s;
                        parity_s    = hdr_s;
                        state_s     = HDR;
                    end else begin
                        pld_ready_s = 1'b1;
                    end
                end else begin
                    pld_ready_s = 1'b1;
                end
            end
            HDR: begin
                if (!busy) begin
                    data_out_s = pld_mem[6'd0];
                    rd_cnt_s   = 6'd0;
                    state_s    = PLD;
                end else begin
                    data_out_s = data_out;
                end
            end
            PLD: begin
                if (!busy) begin
                    parity_s = par_acc(parity_r, data_out);
                    if (rd_cnt_r == (len_r - 6'd1)) begin
                        pkt_valid_s = 1'b0;
                        data_out_s  = par_acc(parity_r, data_out);
                        state_s     = PAR;
                    end else begin
                        rd_cnt_s   = rd_cnt_r + 6'd1;
                        data_out_s = pld_mem[rd_cnt_r + 6'd1];
                    end
                end else begin
                    data_out_s = data_out;
                end
            end
            PAR: begin
                if (!busy) begin
                    data_out_s = 8'h00;
                    sticky_s   = 1'b0;
                    chk_cnt_s  = 4'(CHK_CYCLES);
                    state_s    = CHK;
                end else begin
                    data_out_s = data_out;
                end
            end
            CHK: begin
                // The sample taken on the expiring edge still counts toward the status.
                err_seen_s = sticky_r | err;
                sticky_s   = err_seen_s;
                if (chk_cnt_r == 4'd1) begin
                    if (RETRY_EN && err_seen_s && (retry_r < 2'(MAX_RETRY))) begin
                        retry_s     = retry_r + 2'd1;
                        pkt_valid_s = 1'b1;
                        data_out_s  = hdr_s;
                        parity_s    = hdr_s;
                        state_s     = HDR;
                    end else begin
                        tx_done_s = 1'b1;
                        tx_err_s  = err_seen_s;
                        state_s   = IDLE;
                    end
                end else begin
                    chk_cnt_s = chk_cnt_r - 4'd1;
                end
            end
            default: begin
                state_s     = IDLE;
                pkt_valid_s = 1'b0;
                data_out_s  = 8'h00;
            end
        endcase
    end

    // State, counter and registered-output update with synchronous reset.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_r   <= IDLE;
            addr_r    <= 2'd0;
            len_r     <= 6'd0;
            wr_cnt_r  <= 6'd0;
            rd_cnt_r  <= 6'd0;
            parity_r  <= 8'h00;
            sticky_r  <= 1'b0;
            chk_cnt_r <= 4'd0;
            retry_r   <= 2'd0;
            cmd_ready <= 1'b0;
            pld_ready <= 1'b0;
            pkt_valid <= 1'b0;
            data_out  <= 8'h00;
            tx_done   <= 1'b0;
            tx_err    <= 1'b0;
            tx_rej    <= 1'b0;
        end else begin
            state_r   <= state_s;
            addr_r    <= addr_s;
            len_r     <= len_s;
            wr_cnt_r  <= wr_cnt_s;
            rd_cnt_r  <= rd_cnt_s;
            parity_r  <= parity_s;
            sticky_r  <= sticky_s;
            chk_cnt_r <= chk_cnt_s;
            retry_r   <= retry_s;
            cmd_ready <= cmd_ready_s;
            pld_ready <= pld_ready_s;
            pkt_valid <= pkt_valid_s;
            data_out  <= data_out_s;
            tx_done   <= tx_done_s;
            tx_err    <= tx_err_s;
            tx_rej    <= tx_rej_s;
        end
    end

endmodule

// File: tb/tb_router_pkt_tx.sv
// Scoreboard bench for router_pkt_tx: stimulus queues expected bytes/status, a negedge monitor checks them.
module tb_router_pkt_tx;

    logic       clock;
    logic       reset;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [1:0] cmd_addr;
    logic [5:0] cmd_len;
    logic       pld_valid;
    logic       pld_ready;
    logic [7:0] pld_data;
    logic       pkt_valid;
    logic [7:0] data_out;
    logic       busy;
    logic       err;
    logic       tx_done;
    logic       tx_err;
    logic       tx_rej;

    router_pkt_tx #(.CHK_CYCLES(3), .MAX_RETRY(2)) dut (
        .clock(clock), .reset(reset),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_addr(cmd_addr), .cmd_len(cmd_len),
        .pld_valid(pld_valid), .pld_ready(pld_ready), .pld_data(pld_data),
        .pkt_valid(pkt_valid), .data_out(data_out), .busy(busy), .err(err),
        .tx_done(tx_done), .tx_err(tx_err), .tx_rej(tx_rej)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct packed {
        logic [1:0] kind;
        logic [7:0] data;
        logic       e;
        logic       r;
    } exp_t;

    localparam logic [1:0] K_BYTE = 2'd0;
    localparam logic [1:0] K_PAR  = 2'd1;
    localparam logic [1:0] K_DONE = 2'd2;

    exp_t       sbq[$];
    int         total = 0;
    int         bad   = 0;
    logic [7:0] pay [0:63];
    logic       mon_prev_cons  = 1'b0;
    logic       mon_prev_stall = 1'b0;
    logic [7:0] mon_prev_data  = 8'h00;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h, required %0h", name, act, req);
        end
    endtask

    task automatic timeout(input string name);
        total++;
        bad++;
        $display("FAIL %s: wait expired, required event never seen", name);
    endtask

    task automatic exp_push(input logic [1:0] k, input logic [7:0] d, input logic e, input logic r);
        exp_t x;
        x.kind = k;
        x.data = d;
        x.e    = e;
        x.r    = r;
        sbq.push_back(x);
    endtask

    task automatic pop_cmp(input logic [1:0] k, input logic [7:0] d, input logic e, input logic r);
        exp_t x;
        if (sbq.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_output: got kind=%0d data=%h err=%b rej=%b, required none", k, d, e, r);
        end else begin
            x = sbq.pop_front();
            check("event_kind", 32'(k), 32'(x.kind));
            if (x.kind == K_DONE) begin
                check("done_err", 32'(e), 32'(x.e));
                check("done_rej", 32'(r), 32'(x.r));
            end else if (x.kind == K_PAR) begin
                check("parity_byte", 32'(d), 32'(x.data));
            end else begin
                check("pkt_byte", 32'(d), 32'(x.data));
            end
        end
    endtask

    // Monitor: samples on the falling edge, between input updates and the active edge.
    initial begin
        forever begin
            @(negedge clock);
            if (reset) begin
                mon_prev_cons  = 1'b0;
                mon_prev_stall = 1'b0;
            end else begin
                if (mon_prev_stall) begin
                    check("stall_hold_data", 32'(data_out), 32'(mon_prev_data));
                    check("stall_hold_pv", 32'(pkt_valid), 32'd1);
                end
                if (mon_prev_cons && !pkt_valid) pop_cmp(K_PAR, data_out, 1'b0, 1'b0);
                if (pkt_valid && !busy) pop_cmp(K_BYTE, data_out, 1'b0, 1'b0);
                if (tx_done) pop_cmp(K_DONE, 8'h00, tx_err, tx_rej);
                mon_prev_cons  = pkt_valid && !busy;
                mon_prev_stall = pkt_valid && busy;
                mon_prev_data  = data_out;
            end
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic send_cmd(input logic [1:0] a, input logic [5:0] l);
        logic rdy;
        logic ok;
        ok        = 1'b0;
        cmd_addr  = a;
        cmd_len   = l;
        cmd_valid = 1'b1;
        for (int i = 0; i < 400; i++) begin
            rdy = cmd_ready;
            tick();
            if (rdy) begin
                ok = 1'b1;
                break;
            end
        end
        cmd_valid = 1'b0;
        if (!ok) timeout("cmd_accept");
    endtask

    task automatic feed(input int n, input bit gap);
        logic rdy;
        logic ok;
        for (int i = 0; i < n; i++) begin
            if (gap && (i == 5)) begin
                pld_valid = 1'b0;
                tick();
            end
            pld_valid = 1'b1;
            pld_data  = pay[i];
            ok        = 1'b0;
            for (int j = 0; j < 50; j++) begin
                rdy = pld_ready;
                tick();
                if (rdy) begin
                    ok = 1'b1;
                    break;
                end
            end
            if (!ok) timeout("pld_accept");
        end
        pld_valid = 1'b0;
    endtask

    task automatic wait_done();
        logic ok;
        ok = 1'b0;
        for (int i = 0; i < 400; i++) begin
            if (tx_done) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
        if (!ok) timeout("tx_done");
        tick();
    endtask

    task automatic wait_byte(input logic [7:0] b);
        logic ok;
        ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            if (pkt_valid && (data_out == b)) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
        if (!ok) timeout("wait_byte");
    endtask

    task automatic exp_basic();
        exp_push(K_BYTE, 8'h0D, 1'b0, 1'b0);
        exp_push(K_BYTE, 8'hA5, 1'b0, 1'b0);
        exp_push(K_BYTE, 8'h3C, 1'b0, 1'b0);
        exp_push(K_BYTE, 8'h0F, 1'b0, 1'b0);
        exp_push(K_PAR,  8'h9B, 1'b0, 1'b0);
        exp_push(K_DONE, 8'h00, 1'b0, 1'b0);
    endtask

    initial begin
        reset = 1'b1; cmd_valid = 1'b0; cmd_addr = 2'd0; cmd_len = 6'd0;
        pld_valid = 1'b0; pld_data = 8'h00; busy = 1'b0; err = 1'b0;
        repeat (3) tick();
        check("rst_cmd_ready", 32'(cmd_ready), 32'd0);
        check("rst_pld_ready", 32'(pld_ready), 32'd0);
        check("rst_pkt_valid", 32'(pkt_valid), 32'd0);
        check("rst_data_out", 32'(data_out), 32'd0);
        check("rst_tx_done", 32'(tx_done), 32'd0);
        check("rst_tx_err", 32'(tx_err), 32'd0);
        check("rst_tx_rej", 32'(tx_rej), 32'd0);
        reset = 1'b0;
        tick();
        check("idle_cmd_ready", 32'(cmd_ready), 32'd1);

        // Basic send: header {3,1}=0D, parity 0D^A5^3C^0F=9B.
        pay[0] = 8'hA5; pay[1] = 8'h3C; pay[2] = 8'h0F;
        exp_basic();
        send_cmd(2'd1, 6'd3);
        feed(3, 1'b0);
        wait_done();

        // Busy stall for two cycles while 3C is presented.
        exp_basic();
        send_cmd(2'd1, 6'd3);
        feed(3, 1'b0);
        wait_byte(8'h3C);
        busy = 1'b1;
        tick();
        tick();
        busy = 1'b0;
        wait_done();

        // Illegal commands.
        exp_push(K_DONE, 8'h00, 1'b1, 1'b1);
        send_cmd(2'd3, 6'd4);
        check("rej1_pld_ready", 32'(pld_ready), 32'd0);
        wait_done();
        check("rej1_pkt_valid", 32'(pkt_valid), 32'd0);
        exp_push(K_DONE, 8'h00, 1'b1, 1'b1);
        send_cmd(2'd0, 6'd0);
        check("rej2_pld_ready", 32'(pld_ready), 32'd0);
        wait_done();
        check("rej2_pkt_valid", 32'(pkt_valid), 32'd0);
        check("rej2_pld_ready_after", 32'(pld_ready), 32'd0);

        // Error report: header {1,2}=06, payload 00, parity 06.
        pay[0] = 8'h00;
`ifdef ROUTER_PKT_TX_RETRY_EN
        err = 1'b1;
        for (int k = 0; k < 3; k++) begin
            exp_push(K_BYTE, 8'h06, 1'b0, 1'b0);
            exp_push(K_BYTE, 8'h00, 1'b0, 1'b0);
            exp_push(K_PAR,  8'h06, 1'b0, 1'b0);
        end
        exp_push(K_DONE, 8'h00, 1'b1, 1'b0);
        send_cmd(2'd2, 6'd1);
        feed(1, 1'b0);
        wait_done();
        err = 1'b0;
`else
        exp_push(K_BYTE, 8'h06, 1'b0, 1'b0);
        exp_push(K_BYTE, 8'h00, 1'b0, 1'b0);
        exp_push(K_PAR,  8'h06, 1'b0, 1'b0);
        exp_push(K_DONE, 8'h00, 1'b1, 1'b0);
        send_cmd(2'd2, 6'd1);
        feed(1, 1'b0);
        for (int i = 0; i < 50; i++) begin
            if (!pkt_valid) break;
            tick();
        end
        tick();
        tick();
        err = 1'b1;
        tick();
        err = 1'b0;
        wait_done();
`endif

        // Max length: header FC, payload 00..3E, parity FC^3F=C3.
        for (int i = 0; i < 63; i++) pay[i] = 8'(i);
        exp_push(K_BYTE, 8'hFC, 1'b0, 1'b0);
        for (int i = 0; i < 63; i++) exp_push(K_BYTE, 8'(i), 1'b0, 1'b0);
        exp_push(K_PAR, 8'hC3, 1'b0, 1'b0);
        exp_push(K_DONE, 8'h00, 1'b0, 1'b0);
        send_cmd(2'd0, 6'd63);
        feed(63, 1'b1);
        wait_done();

        // Same packet abandoned by reset while byte 0x14 is on the wire.
        exp_push(K_BYTE, 8'hFC, 1'b0, 1'b0);
        for (int i = 0; i < 20; i++) exp_push(K_BYTE, 8'(i), 1'b0, 1'b0);
        send_cmd(2'd0, 6'd63);
        feed(63, 1'b0);
        wait_byte(8'h14);
        reset = 1'b1;
        tick();
        check("midrst_pkt_valid", 32'(pkt_valid), 32'd0);
        check("midrst_data_out", 32'(data_out), 32'd0);
        check("midrst_cmd_ready", 32'(cmd_ready), 32'd0);
        reset = 1'b0;
        tick();
        check("postrst_cmd_ready", 32'(cmd_ready), 32'd1);
        check("postrst_pkt_valid", 32'(pkt_valid), 32'd0);
        repeat (5) tick();
        check("postrst_no_done", 32'(tx_done), 32'd0);
        check("scoreboard_empty", 32'(sbq.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not finish, required completion");
        $fatal(1);
    end

endmodule
